// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution unit: branch/jump codes,
// 2-bit BHT counter type and state constants, and counter-update helpers.
package branch_pkg;

  typedef enum logic [3:0] {
    BJ_NONE = 4'b0000,
    BJ_BEQ  = 4'b1000,
    BJ_BNE  = 4'b1001,
    BJ_JAL  = 4'b1011,
    BJ_BLT  = 4'b1100,
    BJ_BGE  = 4'b1101,
    BJ_BLTU = 4'b1110,
    BJ_BGEU = 4'b1111
  } bj_inst_e;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_SNT = 2'b00;
  localparam bht_cnt_t CNT_WNT = 2'b01;
  localparam bht_cnt_t CNT_WT  = 2'b10;
  localparam bht_cnt_t CNT_ST  = 2'b11;

  // Conditional branches train the predictor; jumps and other codes do not.
  function automatic logic is_cond_branch(input logic [3:0] code);
    return (code == BJ_BEQ)  || (code == BJ_BNE)  ||
           (code == BJ_BLT)  || (code == BJ_BGE)  ||
           (code == BJ_BLTU) || (code == BJ_BGEU);
  endfunction

  // Saturating 2-bit counter step towards the resolved direction.
  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    if (taken) return (cnt == CNT_ST)  ? CNT_ST  : bht_cnt_t'(cnt + 2'd1);
    else       return (cnt == CNT_SNT) ? CNT_SNT : bht_cnt_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage request and registered resolution bundle between the pipeline
// (master) and the branch resolution unit (slave).
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic [3:0]      ex_bj_inst;
  logic [XLEN-1:0] ex_inA;
  logic [XLEN-1:0] ex_inB;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            stall;
  logic            flush;
  logic            br_valid;
  logic            br_taken;
  logic            br_mispredict;
  logic [XLEN-1:0] br_redirect_pc;

  modport master (
    output ex_valid, ex_bj_inst, ex_inA, ex_inB, ex_pc, ex_target,
           ex_pred_taken, stall, flush,
    input  br_valid, br_taken, br_mispredict, br_redirect_pc
  );

  modport slave (
    input  ex_valid, ex_bj_inst, ex_inA, ex_inB, ex_pc, ex_target,
           ex_pred_taken, stall, flush,
    output br_valid, br_taken, br_mispredict, br_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_unit_br_cmp.sv
// Combinational branch/jump condition evaluator.
module br_cmp
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      code,
  input  logic [XLEN-1:0] inA,
  input  logic [XLEN-1:0] inB,
  output logic            cond
);

  // Resolve direction; unknown codes are never taken.
  always_comb begin
    cond = 1'b0;
    case (code)
      BJ_BEQ:  cond = (inA == inB);
      BJ_BNE:  cond = (inA != inB);
      BJ_JAL:  cond = 1'b1;
      BJ_BLT:  cond = ($signed(inA) <  $signed(inB));
      BJ_BGE:  cond = ($signed(inA) >= $signed(inB));
      BJ_BLTU: cond = (inA <  inB);
      BJ_BGEU: cond = (inA >= inB);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit with bimodal (2-bit counter) predictor.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined;
// otherwise stat_branches/stat_mispredicts are tied to zero.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter bht_cnt_t    CNT_INIT    = CNT_WNT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  if_pred_taken,
  branch_resolve_unit_if.slave  bus,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic            cond;
  logic            accept;
  logic            bht_upd;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  bht_cnt_t bht_q [BHT_ENTRIES];
  bht_cnt_t bht_d [BHT_ENTRIES];

  logic            br_valid_q, br_valid_d;
  logic            br_taken_q, br_taken_d;
  logic            br_mispredict_q, br_mispredict_d;
  logic [XLEN-1:0] br_redirect_pc_q, br_redirect_pc_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  br_cmp #(.XLEN(XLEN)) u_br_cmp (
    .code (bus.ex_bj_inst),
    .inA  (bus.ex_inA),
    .inB  (bus.ex_inB),
    .cond (cond)
  );

  assign accept  = bus.ex_valid && !bus.stall && !bus.flush;
  assign bht_upd = accept && is_cond_branch(bus.ex_bj_inst);
  assign if_idx  = if_pc[IDX_W+1:2];
  assign ex_idx  = bus.ex_pc[IDX_W+1:2];

  // Fetch-side prediction reads the registered table (no write bypass).
  assign if_pred_taken = bht_q[if_idx][1];

  // Next BHT contents: train only on accepted conditional branches.
  always_comb begin
    bht_d = bht_q;
    if (bht_upd) bht_d[ex_idx] = bht_next(bht_q[ex_idx], cond);
  end

  // BHT storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
    end else begin
      bht_q <= bht_d;
    end
  end

  // Output register next-state: flush kills, stall holds, accept resolves.
  always_comb begin
    br_valid_d       = br_valid_q;
    br_taken_d       = br_taken_q;
    br_mispredict_d  = br_mispredict_q;
    br_redirect_pc_d = br_redirect_pc_q;
    if (bus.flush) begin
      br_valid_d = 1'b0;
    end else if (bus.stall) begin
      br_valid_d = br_valid_q;
    end else if (bus.ex_valid) begin
      br_valid_d       = 1'b1;
      br_taken_d       = cond;
      br_mispredict_d  = (cond != bus.ex_pred_taken);
      br_redirect_pc_d = cond ? bus.ex_target : bus.ex_pc + XLEN'(4);
    end else begin
      br_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid_q       <= 1'b0;
      br_taken_q       <= 1'b0;
      br_mispredict_q  <= 1'b0;
      br_redirect_pc_q <= '0;
    end else begin
      br_valid_q       <= br_valid_d;
      br_taken_q       <= br_taken_d;
      br_mispredict_q  <= br_mispredict_d;
      br_redirect_pc_q <= br_redirect_pc_d;
    end
  end

  assign bus.br_valid       = br_valid_q;
  assign bus.br_taken       = br_taken_q;
  assign bus.br_mispredict  = br_mispredict_q;
  assign bus.br_redirect_pc = br_redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Count accepted branches/jumps and accepted mispredicts (wrapping).
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept && (is_cond_branch(bus.ex_bj_inst) || bus.ex_bj_inst == BJ_JAL))
      stat_branches_d = stat_branches_q + 32'd1;
    if (accept && (cond != bus.ex_pred_taken))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized
// traffic against a behavioural model of predictor and resolution outputs.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_resolve_unit_if #(.XLEN(32)) bus ();

  branch_resolve_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .CNT_INIT    (2'b01)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .bus              (bus),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model state
  int          m_bht [64];
  logic        m_valid, m_taken, m_misp;
  logic [31:0] m_redir;
  logic [31:0] m_nbr, m_nmisp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_pred(input logic [31:0] pc);
    return m_bht[(pc / 4) % 64] >= 2;
  endfunction

  function automatic logic model_cond(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (code)
      4'd8:    return a == b;
      4'd9:    return a != b;
      4'd11:   return 1'b1;
      4'd12:   return sa < sb;
      4'd13:   return sa >= sb;
      4'd14:   return a < b;
      4'd15:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_valid = 0; m_taken = 0; m_misp = 0; m_redir = 0;
    m_nbr = 0; m_nmisp = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, {31'd0, bus.br_valid}, {31'd0, m_valid});
    check({tag, ".taken"}, {31'd0, bus.br_taken}, {31'd0, m_taken});
    check({tag, ".misp"}, {31'd0, bus.br_mispredict}, {31'd0, m_misp});
    check({tag, ".redir"}, bus.br_redirect_pc, m_redir);
`ifdef BRANCH_STATS_EN
    check({tag, ".nbr"}, stat_branches, m_nbr);
    check({tag, ".nmisp"}, stat_mispredicts, m_nmisp);
`else
    check({tag, ".nbr"}, stat_branches, 32'd0);
    check({tag, ".nmisp"}, stat_mispredicts, 32'd0);
`endif
  endtask

  // One clock: apply inputs, check the combinational prediction, clock,
  // advance the model and check the registered outputs.
  task automatic drive(input string tag, input logic v, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic st, input logic fl,
                       input logic [31:0] fpc);
    logic c;
    bus.ex_valid = v; bus.ex_bj_inst = code; bus.ex_inA = a; bus.ex_inB = b;
    bus.ex_pc = pc; bus.ex_target = tgt; bus.ex_pred_taken = pred;
    bus.stall = st; bus.flush = fl; if_pc = fpc;
    #1;
    check({tag, ".ifpred"}, {31'd0, if_pred_taken}, {31'd0, model_pred(fpc)});
    @(posedge clk);
    c = model_cond(code, a, b);
    if (fl) begin
      m_valid = 0;
    end else if (!st && v) begin
      m_valid = 1;
      m_taken = c;
      m_misp  = (c != pred);
      m_redir = c ? tgt : pc + 32'd4;
      if (code == 4'd11 || (code[3] && code != 4'd10)) m_nbr = m_nbr + 1;
      if (c != pred) m_nmisp = m_nmisp + 1;
      if (code[3] && code != 4'd10 && code != 4'd11) begin
        if (c) m_bht[(pc / 4) % 64] = (m_bht[(pc / 4) % 64] == 3) ? 3 : m_bht[(pc / 4) % 64] + 1;
        else   m_bht[(pc / 4) % 64] = (m_bht[(pc / 4) % 64] == 0) ? 0 : m_bht[(pc / 4) % 64] - 1;
      end
    end else if (!st) begin
      m_valid = 0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".rst"});
    bus.ex_valid = 0; bus.stall = 0; bus.flush = 0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 0;
    bus.ex_valid = 0; bus.ex_bj_inst = 0; bus.ex_inA = 0; bus.ex_inB = 0;
    bus.ex_pc = 0; bus.ex_target = 0; bus.ex_pred_taken = 0;
    bus.stall = 0; bus.flush = 0;
    model_reset();
    #2;
    check_outputs("reset");
    if_pc = 32'h0;  #1; check("reset.pred0",  {31'd0, if_pred_taken}, 32'd0);
    if_pc = 32'hFC; #1; check("reset.predFC", {31'd0, if_pred_taken}, 32'd0);
    #8 rst_n = 1'b1;

    // Signed vs unsigned compare on the same operands
    drive("blt", 1, 4'b1100, 32'hFFFFFFFF, 1, 32'h40, 32'h80, 0, 0, 0, 32'h40);
    check("blt.taken", {31'd0, bus.br_taken}, 32'd1);
    check("blt.misp",  {31'd0, bus.br_mispredict}, 32'd1);
    check("blt.redir", bus.br_redirect_pc, 32'h80);
    drive("bltu", 1, 4'b1110, 32'hFFFFFFFF, 1, 32'h40, 32'h80, 0, 0, 0, 32'h40);
    check("bltu.taken", {31'd0, bus.br_taken}, 32'd0);
    check("bltu.misp",  {31'd0, bus.br_mispredict}, 32'd0);
    check("bltu.redir", bus.br_redirect_pc, 32'h44);

    // Counter training at index 0 and aliasing
    drive("beq1", 1, 4'b1000, 7, 7, 32'h100, 32'h300, 0, 0, 0, 32'h100);
    check("beq1.pred", {31'd0, if_pred_taken}, 32'd1);
    drive("beq2", 1, 4'b1000, 7, 7, 32'h100, 32'h300, 1, 0, 0, 32'h100);
    drive("beq3", 1, 4'b1000, 7, 8, 32'h100, 32'h300, 1, 0, 0, 32'h100);
    check("beq3.pred", {31'd0, if_pred_taken}, 32'd1);
    if_pc = 32'h200; #1;
    check("alias.pred", {31'd0, if_pred_taken}, 32'd1);

    // Stall holds outputs and BHT; flush wins over stall
    drive("st0", 1, 4'b1000, 3, 4, 32'h100, 32'h300, 0, 0, 0, 32'h100);
    for (int i = 0; i < 3; i++)
      drive("stall", 1, 4'b1000, 3, 4, 32'h100, 32'h300, 1, 1, 0, 32'h100);
    check("stall.valid", {31'd0, bus.br_valid}, 32'd1);
    drive("stfl", 1, 4'b1000, 3, 4, 32'h100, 32'h300, 1, 1, 1, 32'h100);
    check("stfl.valid", {31'd0, bus.br_valid}, 32'd0);

    // Jump and non-branch at the top of the address space
    drive("jal", 1, 4'b1011, 0, 0, 32'hFFFFFFFC, 32'h10, 0, 0, 0, 32'hFFFFFFFC);
    check("jal.redir", bus.br_redirect_pc, 32'h10);
    check("jal.misp", {31'd0, bus.br_mispredict}, 32'd1);
    drive("nobr", 1, 4'b0000, 0, 0, 32'hFFFFFFFC, 32'h10, 1, 0, 0, 32'hFFFFFFFC);
    check("nobr.redir", bus.br_redirect_pc, 32'h0);
    check("nobr.misp", {31'd0, bus.br_mispredict}, 32'd1);

    // Reset in the middle of a stall
    drive("prerst", 1, 4'b1001, 1, 2, 32'h20, 32'h60, 0, 0, 0, 32'h20);
    bus.stall = 1;
    async_reset("midstall");

    // Stats: three accepted branches, one mispredict
    drive("s1", 1, 4'b1000, 5, 5, 32'h8, 32'h88, 1, 0, 0, 32'h8);
    drive("s2", 1, 4'b1001, 5, 5, 32'hC, 32'h88, 0, 0, 0, 32'hC);
    drive("s3", 1, 4'b1011, 0, 0, 32'h10, 32'h88, 0, 0, 0, 32'h10);
`ifdef BRANCH_STATS_EN
    check("stats.br",   stat_branches, 32'd3);
    check("stats.misp", stat_mispredicts, 32'd1);
`else
    check("stats.br",   stat_branches, 32'd0);
    check("stats.misp", stat_mispredicts, 32'd0);
`endif
    idle("idle");

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b, pc, fpc;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 0) begin a[31] = 1'b0; b[31] = $urandom_range(0, 1); end
      pc  = ($urandom_range(0, 7) == 0) ? $urandom : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      fpc = ($urandom_range(0, 1) == 0) ? pc : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      drive("rnd", $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b, pc,
            $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, fpc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch resolution unit with an integrated bimodal predictor.
- Fetch side: reads a table of 2-bit saturating counters (BHT) indexed by fetch PC.
- EX side: evaluates branch/jump conditions (signed and unsigned) and registers the outcome with 1-cycle latency.
- Outputs: mispredict and redirect PC for the pipeline front end; the BHT is trained on every resolved conditional branch.

Parameters:
- XLEN, 32: data/PC width.
- BHT_ENTRIES, 64: number of counters; power of 2, at least 2.
- CNT_INIT, 2'b01: counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  XLEN  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational prediction for if_pc
- ex_valid  in  1  EX holds a valid instruction
- ex_bj_inst  in  4  branch/jump code
- ex_inA  in  XLEN  rs1 operand
- ex_inB  in  XLEN  rs2 operand
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed branch/jump target
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- stall  in  1  hold EX/outputs
- flush  in  1  EX instruction is wrong-path; kill it
- br_valid  out  1  registered outcome valid
- br_taken  out  1  resolved direction
- br_mispredict  out  1  redirect required
- br_redirect_pc  out  XLEN  correct next PC
- stat_branches  out  32  see Optional Feature
- stat_mispredicts  out  32  see Optional Feature

Behaviour:
- Code map:
  - 1000 BEQ; 1001 BNE; 1011 JAL/JALR (always taken).
  - 1100 BLT and 1101 BGE: signed compare.
  - 1110 BLTU and 1111 BGEU: unsigned compare.
  - Any other code: not a branch.
- BHT index = pc[IDX_W+1:2], IDX_W = log2(BHT_ENTRIES). Prediction = counter MSB.
- Reset: all counters = CNT_INIT; br_valid, br_taken, br_mispredict = 0; br_redirect_pc = 0.
- Accept condition: ex_valid && !stall && !flush. On each clk edge:
  - flush=1: br_valid<=0, other outputs hold, no BHT update. Flush has priority over stall.
  - stall=1 (flush=0): all outputs and BHT hold.
  - Accept: br_valid<=1; br_taken<=cond; br_mispredict<=(cond != ex_pred_taken); br_redirect_pc<=cond ? ex_target : ex_pc+4.
  - Otherwise: br_valid<=0, other outputs hold.
- ex_pc+4 is computed mod 2^XLEN (wraps to 0).
- Non-branch code: cond=0, so mispredict equals ex_pred_taken and the redirect is ex_pc+4.
- JAL/JALR: cond=1; mispredict = !ex_pred_taken.
- BHT update: only on accepted conditional branches (codes 1000, 1001, 1100–1111).
  - Taken: counter increments, saturating at 11.
  - Not-taken: counter decrements, saturating at 00.
  - Jumps and non-branches never update.
- Same-cycle read/write of one index: if_pred_taken returns the pre-update value (no bypass). The new value is visible the next cycle.
- Reset asserted mid-operation clears everything asynchronously, including mid-stall state.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - stat_branches counts accepted conditional branches plus jumps.
  - stat_mispredicts counts accepted instructions with mispredict.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package branch_pkg:
  - bj_inst_e enum of the eight codes.
  - bht_cnt_t (2-bit) plus CNT_SNT/WNT/WT/ST constants.
  - is_cond_branch() function.
- Sub-module br_cmp: combinational condition evaluator (code, inA, inB, XLEN) -> cond.
- BHT storage and the output register stay in the top module.

Test Plan:
- Reset, then if_pc=0x0 and 0xFC -> if_pred_taken=0; br_valid=0; both stats=0.
- BLT inA=0xFFFFFFFF, inB=1, pred=0, pc=0x40, target=0x80 -> next cycle taken=1, mispredict=1, redirect=0x80. Same operands with BLTU -> taken=0, mispredict=0, redirect=0x44.
- BEQ at pc 0x100, equal operands, accepted twice -> counter 01->10->11; if_pred_taken(0x100)=1 after the first update. One not-taken -> 10, still predicts 1. Pc 0x200 aliases to index 0 and reads the same counter.
- Accepted BEQ with stall=1 -> outputs and counter unchanged for the stall duration. stall=1 and flush=1 together -> br_valid=0, no update.
- JAL pred=0 at pc 0xFFFFFFFC, target 0x10 -> taken=1, mispredict=1, redirect=0x10, BHT unchanged. Non-branch code 0000 with pred=1 -> mispredict=1, redirect=0x0 (wrap).
- With BRANCH_STATS_EN: 3 accepted branches, 1 mispredicted -> stat_branches=3, stat_mispredicts=1. Without the macro -> both stats 0.
